instr_fetch_unit: RTL and testbench

Instruction fetch and issue sequencer that produces the 6-bit opcode and full instruction word consumed by the main control decoder. Owns the program counter, runs a request/ready handshake to instruction memory, holds the fetched word stable until the datapath acknowledges it, and applies branch/jump redirects. Sits between instruction memory and the decode/control stage of the multi-cycle RISC datapath.

---
 rtl/instr_fetch_unit_pkg.sv | 25 ++
 rtl/instr_fetch_unit_if.sv | 33 +++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode constants: FSM state encoding, opcode field bounds,
// reset PC and the halt opcode the main control decoder also consumes.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] OP_HALT          = 6'b111111;
  localparam logic [XLEN-1:0]     DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } ifu_state_e;

  // Opcode field of an instruction word.
  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [XLEN-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: instruction-memory handshake, issue to decode, and status.
// master = fetch unit, slave = memory/datapath side.
interface instr_fetch_unit_if;

  logic                                        imem_req;
  logic [instr_fetch_unit_pkg::XLEN-1:0]       imem_addr;
  logic                                        imem_ready;
  logic [instr_fetch_unit_pkg::XLEN-1:0]       imem_rdata;
  logic [instr_fetch_unit_pkg::XLEN-1:0]       instr;
  logic [instr_fetch_unit_pkg::OPCODE_W-1:0]   opcode;
  logic                                        instr_valid;
  logic                                        instr_ack;
  logic                                        redirect;
  logic [instr_fetch_unit_pkg::XLEN-1:0]       redirect_pc;
  logic [instr_fetch_unit_pkg::XLEN-1:0]       pc;
  logic [instr_fetch_unit_pkg::XLEN-1:0]       pc_plus4;
  logic                                        halted;
  logic                                        fetch_err;
  logic                                        misalign_err;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid,
           pc, pc_plus4, halted, fetch_err, misalign_err,
    input  imem_ready, imem_rdata, instr_ack, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid,
           pc, pc_plus4, halted, fetch_err, misalign_err,
    output imem_ready, imem_rdata, instr_ack, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue sequencer: owns the PC, fetches over a req/ready
// handshake, holds the word until acked, applies redirects, halts on fault.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0]     RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned         TIMEOUT     = 16,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = OP_HALT
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  ifu_state_e       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             imem_req_q, imem_req_d;
  logic             instr_valid_q, instr_valid_d;
  logic             halted_q, halted_d;
  logic             fetch_err_q, fetch_err_d;
  logic             misalign_err_q, misalign_err_d;

  // Next-state, PC update and error tracking.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    cnt_d          = cnt_q;
    fetch_err_d    = fetch_err_q;
    misalign_err_d = misalign_err_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          cnt_d   = '0;
          state_d = (get_opcode(bus.imem_rdata) == HALT_OPCODE) ? ST_HALT : ST_VALID;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          fetch_err_d = 1'b1;
          state_d     = ST_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_VALID: begin
        if (bus.instr_ack) begin
          if (bus.redirect) begin
            // Misaligned targets are forced to word alignment and flagged.
            pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
            if (bus.redirect_pc[1:0] != 2'b00) misalign_err_d = 1'b1;
          end else begin
            pc_d = pc_q + 32'd4;
          end
          state_d = ST_REQ;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pc_plus4_d    = pc_d + 32'd4;
    imem_req_d    = (state_d == ST_REQ);
    instr_valid_d = (state_d == ST_VALID);
    halted_d      = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pc_q           <= RESET_PC;
      pc_plus4_q     <= RESET_PC + 32'd4;
      instr_q        <= '0;
      cnt_q          <= '0;
      imem_req_q     <= 1'b0;
      instr_valid_q  <= 1'b0;
      halted_q       <= 1'b0;
      fetch_err_q    <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pc_plus4_q     <= pc_plus4_d;
      instr_q        <= instr_d;
      cnt_q          <= cnt_d;
      imem_req_q     <= imem_req_d;
      instr_valid_q  <= instr_valid_d;
      halted_q       <= halted_d;
      fetch_err_q    <= fetch_err_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  // The fetch address is the PC register itself.
  assign bus.imem_req     = imem_req_q;
  assign bus.imem_addr    = pc_q;
  assign bus.instr        = instr_q;
  assign bus.opcode       = get_opcode(instr_q);
  assign bus.instr_valid  = instr_valid_q;
  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4_q;
  assign bus.halted       = halted_q;
  assign bus.fetch_err    = fetch_err_q;
  assign bus.misalign_err = misalign_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle table for the fetch/redirect
// stream plus hand sequences for stalls, timeout, halt and mid-fetch reset.
module tb_instr_fetch_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  instr_fetch_unit_if bus();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ready;
    logic [31:0] rdata;
    logic        ack;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        merr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t v(input logic ready, input logic [31:0] rdata, input logic ack,
                             input logic redir, input logic [31:0] rpc, input logic req,
                             input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                             input logic merr);
    vec_t r;
    r.ready = ready; r.rdata = rdata; r.ack = ack; r.redir = redir; r.rpc = rpc;
    r.req = req; r.valid = valid; r.instr = instr; r.pc = pc; r.merr = merr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ready, input logic [31:0] rdata, input logic ack,
                       input logic redir, input logic [31:0] rpc);
    bus.imem_ready  = ready;
    bus.imem_rdata  = rdata;
    bus.instr_ack   = ack;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  // Leaves the bench at a falling edge with the DUT in IDLE.
  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc4;
    logic [5:0]  exp_op;
    int          n;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    //            ready rdata         ack redir rpc          req val instr         pc           merr
    tbl.push_back(v(0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         32'h0,       0));
    tbl.push_back(v(1, 32'h0400_0001, 0, 0, 32'h0,         1, 0, 32'h0,         32'h0,       0));
    tbl.push_back(v(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h0400_0001, 32'h0,       0));
    tbl.push_back(v(1, 32'h0800_0002, 0, 0, 32'h0,         1, 0, 32'h0400_0001, 32'h4,       0));
    tbl.push_back(v(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h0800_0002, 32'h4,       0));
    tbl.push_back(v(1, 32'h1000_0003, 0, 0, 32'h0,         1, 0, 32'h0800_0002, 32'h8,       0));
    tbl.push_back(v(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h1000_0003, 32'h8,       0));
    tbl.push_back(v(1, 32'h2000_0000, 0, 0, 32'h0,         1, 0, 32'h1000_0003, 32'hC,       0));
    tbl.push_back(v(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h2000_0000, 32'hC,       0));
    tbl.push_back(v(1, 32'h1400_0010, 0, 0, 32'h0,         1, 0, 32'h2000_0000, 32'h10,      0));
    tbl.push_back(v(0, 32'h0,         1, 1, 32'h40,        0, 1, 32'h1400_0010, 32'h10,      0));
    tbl.push_back(v(1, 32'h0800_0010, 0, 0, 32'h0,         1, 0, 32'h1400_0010, 32'h40,      0));
    tbl.push_back(v(0, 32'h0,         1, 1, 32'h43,        0, 1, 32'h0800_0010, 32'h40,      0));
    tbl.push_back(v(0, 32'h0,         0, 1, 32'h100,       1, 0, 32'h0800_0010, 32'h40,      1));
    tbl.push_back(v(1, 32'h0000_0020, 0, 0, 32'h0,         1, 0, 32'h0800_0010, 32'h40,      1));
    tbl.push_back(v(0, 32'h0,         0, 1, 32'h80,        0, 1, 32'h0000_0020, 32'h40,      1));
    tbl.push_back(v(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h0000_0020, 32'h40,      1));
    tbl.push_back(v(1, 32'h3000_0004, 0, 0, 32'h0,         1, 0, 32'h0000_0020, 32'h44,      1));
    tbl.push_back(v(0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 1, 32'h3000_0004, 32'h44,      1));
    tbl.push_back(v(1, 32'h0400_0000, 0, 0, 32'h0,         1, 0, 32'h3000_0004, 32'hFFFF_FFFC, 1));
    tbl.push_back(v(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h0400_0000, 32'hFFFF_FFFC, 1));
    tbl.push_back(v(0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0400_0000, 32'h0,       1));

    // Cycle table: check registered outputs, then drive this cycle's inputs.
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      exp_pc4 = tbl[i].pc + 32'd4;
      exp_op  = tbl[i].instr[31:26];
      chk($sformatf("row%0d_req", i),    32'(bus.imem_req),     32'(tbl[i].req));
      chk($sformatf("row%0d_addr", i),   bus.imem_addr,         tbl[i].pc);
      chk($sformatf("row%0d_valid", i),  32'(bus.instr_valid),  32'(tbl[i].valid));
      chk($sformatf("row%0d_instr", i),  bus.instr,             tbl[i].instr);
      chk($sformatf("row%0d_opcode", i), 32'(bus.opcode),       32'(exp_op));
      chk($sformatf("row%0d_pc", i),     bus.pc,                tbl[i].pc);
      chk($sformatf("row%0d_pc4", i),    bus.pc_plus4,          exp_pc4);
      chk($sformatf("row%0d_merr", i),   32'(bus.misalign_err), 32'(tbl[i].merr));
      chk($sformatf("row%0d_halted", i), 32'(bus.halted),       32'h0);
      chk($sformatf("row%0d_ferr", i),   32'(bus.fetch_err),    32'h0);
      drive(tbl[i].ready, tbl[i].rdata, tbl[i].ack, tbl[i].redir, tbl[i].rpc);
      @(negedge clk);
    end

    // Ready after 3 stall cycles, ack after 4 VALID cycles.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dly_req_hold%0d", i), 32'(bus.imem_req), 32'h1);
      @(negedge clk);
    end
    chk("dly_req_last", 32'(bus.imem_req), 32'h1);
    drive(1'b1, 32'h2C00_1234, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dly_valid%0d", i), 32'(bus.instr_valid), 32'h1);
      chk($sformatf("dly_instr%0d", i), bus.instr, 32'h2C00_1234);
      chk($sformatf("dly_pc%0d", i),    bus.pc, 32'h0);
      chk($sformatf("dly_noreq%0d", i), 32'(bus.imem_req), 32'h0);
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h200);
      @(negedge clk);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("dly_pc_after_ack", bus.pc, 32'h4);
    chk("dly_req_after_ack", 32'(bus.imem_req), 32'h1);
    chk("dly_valid_after_ack", 32'(bus.instr_valid), 32'h0);

    // Memory never ready: 16 request cycles then fault.
    do_reset();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_req) n++;
      @(negedge clk);
    end
    chk("to_req_cycles", 32'(n), 32'd16);
    chk("to_fetch_err", 32'(bus.fetch_err), 32'h1);
    chk("to_halted", 32'(bus.halted), 32'h1);
    chk("to_no_req", 32'(bus.imem_req), 32'h0);

    // Halt opcode: halts without ever issuing the word.
    do_reset();
    @(negedge clk);
    chk("halt_req", 32'(bus.imem_req), 32'h1);
    drive(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("halt_halted", 32'(bus.halted), 32'h1);
    chk("halt_instr", bus.instr, 32'hFC00_0000);
    chk("halt_opcode", 32'(bus.opcode), 32'h3F);
    chk("halt_ferr", 32'(bus.fetch_err), 32'h0);
    drive(1'b1, 32'h0400_0000, 1'b1, 1'b0, 32'h0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.instr_valid || bus.imem_req || !bus.halted) n++;
      @(negedge clk);
    end
    chk("halt_stays", 32'(n), 32'd0);
    chk("halt_instr_kept", bus.instr, 32'hFC00_0000);

    // Reset pulse mid-REQ after a misaligned redirect.
    do_reset();
    @(negedge clk);
    drive(1'b1, 32'h0800_0001, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h21);
    @(negedge clk);
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    chk("rst_pre_merr", 32'(bus.misalign_err), 32'h1);
    chk("rst_pre_pc", bus.pc, 32'h20);
    chk("rst_pre_req", 32'(bus.imem_req), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_pc", bus.pc, 32'h0);
    chk("rst_async_req", 32'(bus.imem_req), 32'h0);
    chk("rst_async_merr", 32'(bus.misalign_err), 32'h0);
    chk("rst_async_instr", bus.instr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst_idle_req", 32'(bus.imem_req), 32'h0);
    chk("rst_idle_instr", bus.instr, 32'h0);
    @(negedge clk);
    chk("rst_first_req", 32'(bus.imem_req), 32'h1);
    chk("rst_first_addr", bus.imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
